uart_sample_tx: RTL and testbench



---
 rtl/uart_sample_tx.sv | 145 ++++++++++++++
 tb/tb_uart_sample_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_sample_tx
// Purpose  : Sends 16-bit debug samples as 8N1 UART bytes, high byte first.
//            A sweep's first sample is preceded by SYNC_BYTE.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sample_tx #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_25mhz,
  input  logic        rst_in,
  input  logic [15:0] sample_in,
  input  logic        first_in,
  input  logic        sample_valid_in,
  output logic        sample_ready_out,
  output logic        busy_out,
  output logic        uart_tx
);

  localparam int                  c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state,    w_state_next;
  logic [c_BAUD_W-1:0] r_baud,     w_baud_next;
  logic [2:0]          r_bit,      w_bit_next;
  logic [1:0]          r_byte_idx, w_byte_idx_next;
  logic [1:0]          r_last_idx, w_last_idx_next;
  logic [23:0]         r_bytes,    w_bytes_next;
  logic                r_tx,       w_tx_next;
  logic                w_accept;
  logic                w_wrap;
  logic [7:0]          w_cur_byte;

  assign sample_ready_out = (r_state == S_IDLE) && !rst_in;
  assign busy_out         = (r_state != S_IDLE);
  assign uart_tx          = r_tx;
  assign w_accept         = sample_valid_in && sample_ready_out;
  assign w_wrap           = (r_baud == c_BAUD_MAX);

  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_last_idx <= '0;
      r_bytes    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_byte_idx <= w_byte_idx_next;
      r_last_idx <= w_last_idx_next;
      r_bytes    <= w_bytes_next;
      r_tx       <= w_tx_next;
    end
  end

  // Byte queue packed MSB-first: slot 0 is [23:16]; non-sync frames use slots 0..1.
  always_comb begin
    w_state_next    = r_state;
    w_baud_next     = r_baud;
    w_bit_next      = r_bit;
    w_byte_idx_next = r_byte_idx;
    w_last_idx_next = r_last_idx;
    w_bytes_next    = r_bytes;

    if (r_state != S_IDLE) begin
      w_baud_next = w_wrap ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next    = S_START;
          w_baud_next     = '0;
          w_bit_next      = '0;
          w_byte_idx_next = '0;
          if (first_in) begin
            w_bytes_next    = {SYNC_BYTE, sample_in};
            w_last_idx_next = 2'd2;
          end else begin
            w_bytes_next    = {sample_in, 8'h00};
            w_last_idx_next = 2'd1;
          end
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          w_bit_next = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          if (r_byte_idx == r_last_idx) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next    = S_START;
            w_byte_idx_next = r_byte_idx + 2'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so the register holds the
  // start bit in the very cycle after the accepting edge.
  always_comb begin
    w_cur_byte = r_bytes[7:0];
    case (w_byte_idx_next)
      2'd0:    w_cur_byte = r_bytes[23:16];
      2'd1:    w_cur_byte = r_bytes[15:8];
      default: w_cur_byte = r_bytes[7:0];
    endcase

    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_cur_byte[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sample_tx
// Purpose  : Self-checking bench for uart_sample_tx at 4 and 217 clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sample_tx;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample;
  logic        first;
  logic        valid4, valid217;
  logic        ready4, busy4, tx4;
  logic        ready217, busy217, tx217;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #20 clk = ~clk;

  uart_sample_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) u_dut4 (
    .clk_25mhz        (clk),
    .rst_in           (rst),
    .sample_in        (sample),
    .first_in         (first),
    .sample_valid_in  (valid4),
    .sample_ready_out (ready4),
    .busy_out         (busy4),
    .uart_tx          (tx4)
  );

  uart_sample_tx #(.CLKS_PER_BIT(217), .SYNC_BYTE(8'hA5)) u_dut217 (
    .clk_25mhz        (clk),
    .rst_in           (rst),
    .sample_in        (sample),
    .first_in         (first),
    .sample_valid_in  (valid217),
    .sample_ready_out (ready217),
    .busy_out         (busy217),
    .uart_tx          (tx217)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for every cycle of a frame: start, 8 data LSB first, stop.
  task automatic build_exp(input int cpb, input logic [15:0] s, input bit f);
    logic [7:0] bq[$];
    logic [7:0] cur;
    exp_q.delete();
    if (f) bq.push_back(SYNC);
    bq.push_back(s[15:8]);
    bq.push_back(s[7:0]);
    foreach (bq[i]) begin
      cur = bq[i];
      repeat (cpb) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (cpb) exp_q.push_back(cur[b]);
      repeat (cpb) exp_q.push_back(1'b1);
    end
  endtask

  task automatic check_frame(input bit sel, input logic [15:0] s, input bit f, input bit scramble);
    build_exp(sel ? 217 : 4, s, f);
    for (int k = 0; k < exp_q.size(); k++) begin
      check("frame_tx",    sel ? tx217    : tx4,    exp_q[k]);
      check("frame_busy",  sel ? busy217  : busy4,  1);
      check("frame_ready", sel ? ready217 : ready4, 0);
      if (scramble && k == 3) begin
        sample = 16'($urandom);
        first  = 1'($urandom);
      end
      tick();
    end
    check("end_busy",  sel ? busy217  : busy4,  0);
    check("end_ready", sel ? ready217 : ready4, 1);
    check("end_tx",    sel ? tx217    : tx4,    1);
  endtask

  task automatic accept(input bit sel, input logic [15:0] s, input bit f);
    check("pre_ready", sel ? ready217 : ready4, 1);
    sample = s;
    first  = f;
    if (sel) valid217 = 1'b1; else valid4 = 1'b1;
    tick();
    valid4   = 1'b0;
    valid217 = 1'b0;
  endtask

  initial begin
    logic [15:0] rs;
    bit          rf;

    rst = 1'b1; sample = 16'h0; first = 1'b0;
    valid4 = 1'b1; valid217 = 1'b1;

    // Reset held three cycles with valid asserted: nothing may be accepted.
    repeat (3) begin
      tick();
      check("rst_tx4",      tx4,      1);
      check("rst_busy4",    busy4,    0);
      check("rst_ready4",   ready4,   0);
      check("rst_tx217",    tx217,    1);
      check("rst_busy217",  busy217,  0);
      check("rst_ready217", ready217, 0);
    end
    rst = 1'b0; valid4 = 1'b0; valid217 = 1'b0;
    #1;
    check("rel_ready4",   ready4,   1);
    check("rel_ready217", ready217, 1);
    tick();
    check("rel_busy4",    busy4,    0);
    check("rel_busy217",  busy217,  0);
    check("rel_tx4",      tx4,      1);

    // Plain two-byte frame, then sync-prefixed three-byte frame.
    accept(0, 16'h1234, 0);
    check_frame(0, 16'h1234, 0, 1);
    tick();
    accept(0, 16'hBEEF, 1);
    check_frame(0, 16'hBEEF, 1, 1);
    tick();

    // Valid held high across two frames: exactly one idle-high cycle between.
    sample = 16'h0001; first = 1'b0; valid4 = 1'b1;
    tick();
    sample = 16'h8000;
    check_frame(0, 16'h0001, 0, 0);
    tick();
    valid4 = 1'b0;
    check_frame(0, 16'h8000, 0, 0);
    tick();

    // Reset pulsed during bit 3 of the first byte aborts the frame.
    accept(0, 16'h00FF, 0);
    build_exp(4, 16'h00FF, 0);
    for (int k = 0; k < 17; k++) begin
      check("pre_rst_tx", tx4, exp_q[k]);
      tick();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ready4, 0);
    check("mid_rst_tx",    tx4,    exp_q[17]);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_tx",    tx4,    1);
    check("post_rst_busy",  busy4,  0);
    check("post_rst_ready", ready4, 1);
    repeat (60) begin
      tick();
      check("abort_tx",   tx4,   1);
      check("abort_busy", busy4, 0);
    end

    // Random samples with random sync flag and idle gaps.
    for (int n = 0; n < 10; n++) begin
      rs = 16'($urandom);
      rf = 1'($urandom);
      accept(0, rs, rf);
      check_frame(0, rs, rf, 1);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("gap_tx",   tx4,   1);
        check("gap_busy", busy4, 0);
      end
      tick();
    end

    // Full-rate bit timing.
    accept(1, 16'h5A5A, 0);
    check_frame(1, 16'h5A5A, 0, 0);
    tick();
    rs = 16'($urandom);
    accept(1, rs, 1);
    check_frame(1, rs, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
